// File: rtl/block_serializer_64x8bit.sv
// Ping-pong serializer: accepts 512-bit 8x8 blocks and streams one pixel per beat,
// in raster or JPEG zigzag order chosen at elaboration.

module block_serializer_64x8bit_slot #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             load,
  input  logic [DEPTH*DATA_WIDTH-1:0]      blk_data,
  input  logic [$clog2(DEPTH)-1:0]         rd_pos,
  output logic [DATA_WIDTH-1:0]            rd_data
);
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  // Pixel 0 arrives in the MSB byte; mem[i] holds raster pixel i.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem <= '0;
    end else if (load) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= blk_data[DEPTH*DATA_WIDTH-1-DATA_WIDTH*i -: DATA_WIDTH];
    end
  end

  assign rd_data = mem[rd_pos];
endmodule

module block_serializer_64x8bit #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int ZIGZAG     = 0
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        blk_valid,
  output logic                        blk_ready,
  input  logic [DEPTH*DATA_WIDTH-1:0] blk_data_512,
  output logic                        pix_valid,
  input  logic                        pix_ready,
  output logic [DATA_WIDTH-1:0]       pix_data,
  output logic [5:0]                  pix_index,
  output logic                        pix_last,
  output logic                        busy
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [5:0]            index;
    logic                  last;
  } pix_t;

  localparam logic [5:0] ZZ_TAB [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  occ_t                             occ, occ_nxt;
  logic                             wr_sel, rd_sel;
  logic [AW-1:0]                    rd_cnt;
  logic [AW-1:0]                    pos;
  logic                             load, beat, last_beat;
  logic [1:0]                       slot_load;
  logic [1:0][DATA_WIDTH-1:0]       slot_pix;
  pix_t                             pix;

  assign load      = blk_valid && blk_ready;
  assign beat      = pix_valid && pix_ready;
  assign last_beat = beat && (rd_cnt == AW'(DEPTH-1));
  assign pos       = (ZIGZAG != 0) ? ZZ_TAB[rd_cnt] : rd_cnt;
  assign slot_load = {load & wr_sel, load & ~wr_sel};

  // Both slots are read at the same position; rd_sel picks the draining one.
  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_slot
      block_serializer_64x8bit_slot #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
      ) u_slot (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (slot_load[g]),
        .blk_data(blk_data_512),
        .rd_pos  (pos),
        .rd_data (slot_pix[g])
      );
    end
  endgenerate

  // Occupancy FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) occ <= EMPTY;
    else          occ <= occ_nxt;
  end

  // Occupancy FSM: next state; a load coinciding with a last beat leaves occ unchanged
  always_comb begin
    occ_nxt = occ;
    unique case (occ)
      EMPTY: if (load) occ_nxt = ONE;
      ONE: begin
        if (load && !last_beat)      occ_nxt = FULL;
        else if (!load && last_beat) occ_nxt = EMPTY;
      end
      FULL:    if (last_beat) occ_nxt = ONE;
      default: occ_nxt = EMPTY;
    endcase
  end

  // Occupancy FSM: outputs depend on registered state only
  always_comb begin
    blk_ready = (occ != FULL);
    pix_valid = (occ != EMPTY);
    busy      = (occ != EMPTY);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      rd_cnt <= '0;
    end else begin
      if (load)      wr_sel <= ~wr_sel;
      if (beat)      rd_cnt <= rd_cnt + 1'b1;
      if (last_beat) rd_sel <= ~rd_sel;
    end
  end

  always_comb begin
    pix = '0;
    if (pix_valid) begin
      pix.data  = slot_pix[rd_sel];
      pix.index = 6'(pos);
      pix.last  = (rd_cnt == AW'(DEPTH-1));
    end
  end

  assign pix_data  = pix.data;
  assign pix_index = pix.index;
  assign pix_last  = pix.last;
endmodule
